// File: rtl/avg_pkg.sv
// Shared types and screen limits for the AVG line rasterizer path.
// The queue entry layout in line_t matches the line-register queue fields.
package avg_pkg;

  localparam int COORD_W = 11;
  localparam int XMAX    = 639;
  localparam int YMAX    = 479;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [2:0]         color_t;

  // dx/dy need one extra bit for the sign; err needs one more for dx+dy.
  typedef logic signed [COORD_W:0]   delta_t;
  typedef logic signed [COORD_W+1:0] err_t;

  typedef struct packed {
    coord_t start_x;
    coord_t start_y;
    coord_t end_x;
    coord_t end_y;
    color_t color;
  } line_t;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

endpackage

// File: rtl/bresenham_setup.sv
// Combinational Bresenham setup: per-line deltas, step directions and initial error.
// Shared by the idle load and the zero-bubble back-to-back load.
module bresenham_setup
  import avg_pkg::*;
(
  input  line_t  i_line,
  output delta_t o_dx,
  output delta_t o_dy,
  output logic   o_sx_neg,
  output logic   o_sy_neg,
  output err_t   o_err0
);

  delta_t w_diff_x;
  delta_t w_diff_y;

  // Zero-extended operands keep the difference exact for any 11-bit input.
  assign w_diff_x = $signed({1'b0, i_line.end_x}) - $signed({1'b0, i_line.start_x});
  assign w_diff_y = $signed({1'b0, i_line.end_y}) - $signed({1'b0, i_line.start_y});

  assign o_sx_neg = w_diff_x[COORD_W];
  assign o_sy_neg = w_diff_y[COORD_W];

  assign o_dx = o_sx_neg ? -w_diff_x : w_diff_x;
  assign o_dy = o_sy_neg ? w_diff_y : -w_diff_y;

  assign o_err0 = $signed({o_dx[COORD_W], o_dx}) + $signed({o_dy[COORD_W], o_dy});

endmodule

// File: rtl/line_rasterizer.sv
// Pops line segments from a FWFT queue and emits one Bresenham pixel per cycle,
// suppressing writes for pixels beyond the visible screen.
module line_rasterizer #(
  parameter int COORD_W = avg_pkg::COORD_W,
  parameter int XMAX    = avg_pkg::XMAX,
  parameter int YMAX    = avg_pkg::YMAX
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [COORD_W-1:0] q_start_x,
  input  logic [COORD_W-1:0] q_start_y,
  input  logic [COORD_W-1:0] q_end_x,
  input  logic [COORD_W-1:0] q_end_y,
  input  logic [2:0]         q_color,
  input  logic               q_empty,
  output logic               q_read,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [2:0]         pix_color,
  output logic               pix_we,
  input  logic               pix_ready,
  output logic               busy
);
  import avg_pkg::*;

  localparam coord_t LIM_X = coord_t'(XMAX);
  localparam coord_t LIM_Y = coord_t'(YMAX);
  localparam coord_t C_ONE = coord_t'(1);

  state_t r_state;
  state_t w_state_next;

  coord_t r_x;
  coord_t r_y;
  coord_t r_ex;
  coord_t r_ey;
  color_t r_color;
  delta_t r_dx;
  delta_t r_dy;
  logic   r_sx_neg;
  logic   r_sy_neg;
  err_t   r_err;

  line_t  w_q_line;
  delta_t w_set_dx;
  delta_t w_set_dy;
  logic   w_set_sx_neg;
  logic   w_set_sy_neg;
  err_t   w_set_err0;

  logic   w_visible;
  logic   w_last;
  logic   w_retire;

  logic signed [COORD_W+2:0] w_e2;
  logic signed [COORD_W+2:0] w_dx_ext;
  logic signed [COORD_W+2:0] w_dy_ext;
  logic   w_step_x;
  logic   w_step_y;
  err_t   w_err_next;
  coord_t w_x_next;
  coord_t w_y_next;

  assign w_q_line = {q_start_x, q_start_y, q_end_x, q_end_y, q_color};

  bresenham_setup u_setup (
    .i_line   (w_q_line),
    .o_dx     (w_set_dx),
    .o_dy     (w_set_dy),
    .o_sx_neg (w_set_sx_neg),
    .o_sy_neg (w_set_sy_neg),
    .o_err0   (w_set_err0)
  );

  assign w_visible = (r_x <= LIM_X) && (r_y <= LIM_Y);
  assign w_last    = (r_x == r_ex) && (r_y == r_ey);

  assign pix_x     = r_x;
  assign pix_y     = r_y;
  assign pix_color = r_color;

  // Bresenham step: e2 = 2*err compared against the sign-extended deltas.
  assign w_e2     = {r_err, 1'b0};
  assign w_dx_ext = {{2{r_dx[COORD_W]}}, r_dx};
  assign w_dy_ext = {{2{r_dy[COORD_W]}}, r_dy};
  assign w_step_x = (w_e2 >= w_dy_ext);
  assign w_step_y = (w_e2 <= w_dx_ext);

  always_comb begin
    w_err_next = r_err;
    w_x_next   = r_x;
    w_y_next   = r_y;
    if (w_step_x) begin
      w_err_next = w_err_next + {r_dy[COORD_W], r_dy};
      w_x_next   = r_sx_neg ? (r_x - C_ONE) : (r_x + C_ONE);
    end
    if (w_step_y) begin
      w_err_next = w_err_next + {r_dx[COORD_W], r_dx};
      w_y_next   = r_sy_neg ? (r_y - C_ONE) : (r_y + C_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clipped pixels retire at once; visible ones wait for the framebuffer.
  always_comb begin
    w_state_next = r_state;
    q_read       = 1'b0;
    pix_we       = 1'b0;
    busy         = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!q_empty) begin
          q_read       = 1'b1;
          w_state_next = DRAW;
        end
      end
      DRAW: begin
        busy     = 1'b1;
        pix_we   = w_visible;
        w_retire = !w_visible || pix_ready;
        if (w_retire && w_last) begin
          if (!q_empty) begin
            q_read = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_x      <= '0;
      r_y      <= '0;
      r_ex     <= '0;
      r_ey     <= '0;
      r_color  <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_err    <= '0;
    end else if (q_read) begin
      r_x      <= q_start_x;
      r_y      <= q_start_y;
      r_ex     <= q_end_x;
      r_ey     <= q_end_y;
      r_color  <= q_color;
      r_dx     <= w_set_dx;
      r_dy     <= w_set_dy;
      r_sx_neg <= w_set_sx_neg;
      r_sy_neg <= w_set_sy_neg;
      r_err    <= w_set_err0;
    end else if (w_retire && !w_last) begin
      r_x   <= w_x_next;
      r_y   <= w_y_next;
      r_err <= w_err_next;
    end
  end

endmodule
